// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares one D-cache port between the LSQ load port and the PCSB store drain
// ports: clk, rst (async, active-high), flush
//        ld_req/ld_addr/ld_rmask -> ld_resp/ld_rdata   (load requester)
//        st_req/st_urgent/st_addr/st_wmask/st_wdata -> st_resp   (store drain)
//        dcache_addr/rmask/wmask/wdata (registered) <- dcache_rdata/dcache_resp   (cache port)
module dcache_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [3:0]  ld_rmask,
    output logic        ld_resp,
    output logic [31:0] ld_rdata,
    input  logic        st_req,
    input  logic        st_urgent,
    input  logic [31:0] st_addr,
    input  logic [3:0]  st_wmask,
    input  logic [31:0] st_wdata,
    output logic        st_resp,
    output logic [31:0] dcache_addr,
    output logic [3:0]  dcache_rmask,
    output logic [3:0]  dcache_wmask,
    output logic [31:0] dcache_wdata,
    input  logic [31:0] dcache_rdata,
    input  logic        dcache_resp
);
    typedef enum logic [1:0] {IDLE, LD_BUSY, ST_BUSY, LD_SQUASH} state_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    state_t state, state_nx;
    logic [3:0] starve_cnt, starve_nx;
    logic free, ld_ok, st_ok, st_win, ld_win;
    always_comb begin
        free      = state == IDLE || dcache_resp;
        // a requester completing this cycle still shows its stale req, so it sits out
        ld_ok     = ld_req && !flush && !(state == LD_BUSY && dcache_resp);
        st_ok     = st_req && !(state == ST_BUSY && dcache_resp);
        st_win    = free && st_ok && (st_urgent || starve_cnt == LIMIT || !ld_ok);
        ld_win    = free && ld_ok && !st_win;
        state_nx  = st_win ? ST_BUSY :
                    ld_win ? LD_BUSY :
                    free   ? IDLE :
                    (state == LD_BUSY && flush) ? LD_SQUASH : state;
        starve_nx = (!st_req || st_win) ? 4'd0 :
                    (ld_win && starve_cnt != LIMIT) ? starve_cnt + 4'd1 : starve_cnt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            starve_cnt   <= 4'd0;
            dcache_addr  <= 32'd0;
            dcache_rmask <= 4'd0;
            dcache_wmask <= 4'd0;
            dcache_wdata <= 32'd0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
            // port outputs only move when the port frees up; a squashed load keeps driving
            if (free) begin
                dcache_rmask <= ld_win ? ld_rmask : 4'd0;
                dcache_wmask <= st_win ? st_wmask : 4'd0;
                if (st_win) begin
                    dcache_addr  <= st_addr;
                    dcache_wdata <= st_wdata;
                end else if (ld_win) begin
                    dcache_addr <= ld_addr;
                end
            end
        end
    end
    assign ld_resp  = dcache_resp && state == LD_BUSY && !flush;
    assign ld_rdata = dcache_rdata;
    assign st_resp  = dcache_resp && state == ST_BUSY;
endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single D-cache port between two requesters: the LSQ load port (read-only) and the post-commit store buffer (PCSB) drain (write-only).
- Sits between the LSQ/PCSB and the D-cache. It grants one request at a time, registers it onto the cache port, and routes the cache response back to the granted requester.
- Loads have priority by default. A starvation counter and an urgent input guarantee forward progress for stores.
- Squashes in-flight load responses on pipeline flush. Committed stores are never affected by flush.

Parameters:
- STARVE_LIMIT, 4, number of consecutive load grants allowed while a store is pending before the store is forced through (range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush; kills load requests and any in-flight load response
- ld_req  in  1  load request valid; held until ld_resp
- ld_addr  in  32  load word address (bits 1:0 = 0)
- ld_rmask  in  4  load byte read mask (nonzero when ld_req)
- ld_resp  out  1  load completion pulse
- ld_rdata  out  32  load data, valid with ld_resp
- st_req  in  1  store drain request valid; held until st_resp
- st_urgent  in  1  PCSB near-full; store wins the next arbitration
- st_addr  in  32  store word address
- st_wmask  in  4  store byte write mask
- st_wdata  in  32  store data, byte-lane aligned
- st_resp  out  1  store completion pulse
- dcache_addr  out  32  cache address (registered)
- dcache_rmask  out  4  cache read mask (registered)
- dcache_wmask  out  4  cache write mask (registered)
- dcache_wdata  out  32  cache write data (registered)
- dcache_rdata  in  32  cache read data, valid with dcache_resp
- dcache_resp  in  1  cache completion pulse

Behaviour:
- States:
  - IDLE: port free.
  - LD_BUSY: load in flight.
  - ST_BUSY: store in flight.
  - LD_SQUASH: flushed load in flight, response discarded.
- Reset (asynchronous): state = IDLE, starve_cnt = 0, and dcache_addr/rmask/wmask/wdata = 0.
  - ld_resp and st_resp are combinational from state and dcache_resp, so they are 0 during reset.
- Cache port protocol:
  - Outputs are held stable from issue until the cycle dcache_resp = 1 inclusive.
  - Never are rmask and wmask both nonzero.
  - In IDLE, both masks are 0.
- Arbitration occurs in any cycle where the port is free for the next edge: state IDLE, or state is BUSY/SQUASH with dcache_resp = 1.
  - The requester completing in the current cycle is excluded from arbitration in that cycle, because its req is still stale.
  - Eligible load: ld_req && !flush. Eligible store: st_req.
  - Store wins if it is eligible and at least one of these holds: st_urgent, starve_cnt == STARVE_LIMIT, or no eligible load. Otherwise an eligible load wins.
- Grant effects, registered on the next edge:
  - Load grant: addr = ld_addr, rmask = ld_rmask, wmask = 0, state → LD_BUSY.
  - Store grant: addr = st_addr, wmask = st_wmask, wdata = st_wdata, rmask = 0, state → ST_BUSY.
  - No grant: masks = 0, state → IDLE.
- Issue latency: a request seen in IDLE in cycle N drives the cache from N+1. Back-to-back issue is allowed: the next request is issued in M+1 when the response arrives in M.
- Responses (combinational, same cycle as dcache_resp):
  - ld_resp = dcache_resp && state == LD_BUSY && !flush.
  - ld_rdata = dcache_rdata.
  - st_resp = dcache_resp && state == ST_BUSY.
- Starvation counter (4-bit):
  - On a load grant while st_req = 1: increment, saturating at STARVE_LIMIT.
  - On a store grant: clear to 0.
  - When st_req = 0: clear to 0.
  - Otherwise hold.
- Flush:
  - In LD_BUSY without dcache_resp: state → LD_SQUASH. The cache outputs stay unchanged because the cache access cannot be aborted.
  - In LD_SQUASH, dcache_resp ends the access with no ld_resp, and arbitration proceeds as normal.
  - Flush coincident with dcache_resp in LD_BUSY: no ld_resp.
  - In ST_BUSY or IDLE, flush only blocks load eligibility.
  - Stores in flight always complete and pulse st_resp.
- If dcache_resp = 1 while in IDLE, it is ignored: no responses are produced.

Test Plan:
- Reset with ld_req = 1 held → all cache masks 0, ld_resp = 0. After release, rmask = ld_rmask on the second cycle, dcache_addr = ld_addr = 0x1000.
- ld_req and st_req both held, cache responds 2 cycles after each issue, STARVE_LIMIT = 4 → grant order L,L,L,L,S,L… with st_resp exactly once; st_wmask = 4'b0011 and wdata = 0x0000BEEF appear on the cache port for the store.
- st_urgent = 1 with ld_req = 1 pending → store granted first; load issued the cycle after st_resp (back-to-back, no idle cycle).
- Load to 0x2004 in flight, flush pulsed one cycle, dcache_resp 3 cycles later with rdata 0xDEADBEEF → no ld_resp; rmask stays 4'b1111 until the response; state returns to IDLE.
- Flush during ST_BUSY → st_resp still pulses on dcache_resp; a load requested in the flush cycle is not granted.
- Asynchronous reset asserted mid-LD_BUSY, between clock edges → masks are 0 immediately; a late dcache_resp after reset produces no ld_resp and no st_resp.
